alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
- Execute-stage controller sitting directly upstream and downstream of the 16-bit combinational ALU.
- Accepts a decoded instruction over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU operand and opcode inputs, captures the ALU result and flags, then writes back the destination register and the status flags.
- Multi-cycle and non-pipelined: one instruction in flight at a time.

Parameters:
- DW, 16, datapath width; matches ALU operand width.
- NREGS, 8, number of general registers.
- RAW, 3, register address width (log2 NREGS).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  controller can accept an instruction.
- in_op  in  3  ALU code: 000 ADD, 001 SUB, 010 SHR, 011 SHL, 100 AND, 101 OR, 110 NOT, 111 XOR.
- in_rd  in  RAW  destination register.
- in_rs1  in  RAW  source register for A.
- in_rs2  in  RAW  source register for B.
- in_use_imm  in  1  B taken from in_imm instead of rs2.
- in_imm  in  DW  immediate operand.
- alu_a  out  DW  ALU operand A.
- alu_b  out  DW  ALU operand B.
- alu_code  out  3  ALU opcode.
- alu_out  in  DW  ALU result.
- alu_carry  in  1  ALU carry.
- alu_zero  in  1  ALU zero flag.
- done  out  1  one-cycle pulse on writeback.
- result  out  DW  written value; valid while done=1.
- flag_c  out  1  carry status flag.
- flag_z  out  1  zero status flag.
- dbg_addr  in  RAW  debug read address.
- dbg_data  out  DW  combinational read of register dbg_addr.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; all registers, flag_c, flag_z, result and alu_a/alu_b/alu_code clear to 0.
  - done=0; in_ready=1 once rst_n is high.
  - Reset mid-instruction aborts it: no writeback and no flag change.
- Register r0 reads as 0; writes to r0 are discarded. The flags still update on such writes.
- FSM states are IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at the edge: latch op and rd; latch A=R[rs1]; latch B=in_use_imm ? in_imm : R[rs2]. Go to EXEC.
  - in_valid=0 holds in IDLE.
- EXEC:
  - in_ready=0; alu_a, alu_b and alu_code are driven from the latched values.
  - At the edge: capture alu_out, alu_carry and alu_zero into internal registers. Go to WB.
- WB:
  - in_ready=0; done=1; result = captured alu_out.
  - At the edge: R[rd] <= result (unless rd=0); flag_z <= captured zero; flag_c <= captured carry only when op=000, otherwise flag_c holds. Go to IDLE.
- Latency and throughput:
  - An instruction accepted at edge T has done high in the cycle after edge T+1.
  - Its register write is visible from edge T+2.
  - Throughput is 1 instruction per 3 cycles.
- Hazards: the next accept happens in IDLE after the WB edge, so it always reads updated state. No bypass is required and no read-after-write (RAW) hazard exists.
- ALU operand outputs hold their last values in IDLE and WB; the ALU result is sampled only at the end of EXEC.
- in_valid and instruction fields are ignored outside IDLE. The producer must hold them until in_ready&&in_valid.
- dbg_data is a combinational read of the array and does not reflect a same-cycle write.
- Widths: no width conversion. The result is exactly DW bits; carry comes from the ALU only.

Decomposition:
- Shared package exec_pkg holds:
  - ALU opcode constants (OP_ADD … OP_XOR, 3 bits).
  - FSM state enum (S_IDLE, S_EXEC, S_WB).
  - DW/RAW defaults.
- One natural sub-module: reg_file. NREGS×DW, 2 combinational read ports plus debug read, 1 synchronous write port, r0 forced to 0, asynchronous active-low clear.
- Controller FSM, operand latches and flag registers stay in alu_exec_ctrl.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then check idle outputs: in_ready=1, flag_c=0, flag_z=0, done=0, dbg_data=0 for all addresses.
- Immediate load: ADD r1=r0+imm 0x00FF, then ADD r2=r0+imm 0xFF01, then ADD r3=r1+r2. Expect r3=0x0000, flag_c=1, flag_z=1, done pulses 3 times, and each result reaches dbg_data 2 edges after accept.
- Carry retention: after the previous scenario, issue XOR r4=r1^r1. Expect r4=0, flag_z=1, flag_c stays 1. Then SUB r5=r1-imm 1: expect 0x00FE, flag_z=0, flag_c still 1.
- r0 protection and handshake: issue ADD r0=r0+imm 5 with in_valid held high continuously. Expect dbg r0=0 and flag_z=0. Expect in_ready low for exactly 2 cycles per instruction, with no double acceptance.
- Shifts and NOT: r1=0x8001. SHL → 0x0002, SHR → 0x4000, NOT → 0x7FFE, each written to a distinct rd.
- Reset mid-op: pull rst_n low during EXEC of ADD r6=r0+imm 0x1234. Expect r6=0, no done pulse, FSM in IDLE, in_ready=1 after release.

Source files
------------

// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execute-stage controller and its register file:
//   - default datapath / register-file geometry
//   - 3-bit ALU opcode constants (OP_ADD .. OP_XOR)
//   - controller FSM state encoding
//   - small helper deciding which opcodes are allowed to touch the carry flag
// -----------------------------------------------------------------------------
package exec_pkg;

    localparam int DW_DEF    = 16;
    localparam int NREGS_DEF = 8;
    localparam int RAW_DEF   = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10
    } state_e;

    // Only an ADD produces an architecturally meaningful carry; every other
    // opcode leaves the carry status flag untouched.
    function automatic logic op_updates_carry(input logic [2:0] op);
        return (op == OP_ADD);
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_reg_file.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl_reg_file (module reg_file)
// NREGS x DW general register file.
//   - two combinational read ports (operand A / operand B)
//   - one combinational debug read port
//   - one synchronous write port
//   - r0 is hard-wired to zero: reads return 0, writes are dropped
//   - asynchronous active-low clear of every entry
// Ports:
//   clk, rst_n              clock, async active-low clear
//   rd_addr_a / rd_data_a   read port A
//   rd_addr_b / rd_data_b   read port B
//   dbg_addr  / dbg_data    debug read port
//   wr_en, wr_addr, wr_data write port (takes effect on rising edge)
// -----------------------------------------------------------------------------
module reg_file
    import exec_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int RAW   = RAW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [RAW-1:0] rd_addr_a,
    output logic [DW-1:0]  rd_data_a,
    input  logic [RAW-1:0] rd_addr_b,
    output logic [DW-1:0]  rd_data_b,
    input  logic [RAW-1:0] dbg_addr,
    output logic [DW-1:0]  dbg_data,
    input  logic           wr_en,
    input  logic [RAW-1:0] wr_addr,
    input  logic [DW-1:0]  wr_data
);

    logic [DW-1:0] regs_r [NREGS];
    logic          wr_ok_s;

    // r0 is never written, so its storage only ever holds the reset value.
    assign wr_ok_s = wr_en && (wr_addr != {RAW{1'b0}});

    // Register array: async clear, synchronous single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (wr_ok_s) begin
                regs_r[wr_addr] <= wr_data;
            end
        end
    end

    // Read ports force r0 to zero explicitly rather than trusting storage.
    assign rd_data_a = (rd_addr_a == {RAW{1'b0}}) ? {DW{1'b0}} : regs_r[rd_addr_a];
    assign rd_data_b = (rd_addr_b == {RAW{1'b0}}) ? {DW{1'b0}} : regs_r[rd_addr_b];
    assign dbg_data  = (dbg_addr  == {RAW{1'b0}}) ? {DW{1'b0}} : regs_r[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// alu_exec_ctrl
// Execute-stage controller wrapped around an external combinational ALU.
// One instruction in flight: IDLE -> EXEC -> WB -> IDLE (3 cycles/instr).
//   IDLE : in_ready=1; on in_valid latch op, rd and operands, go EXEC
//   EXEC : ALU operands/opcode driven from latches; capture ALU outputs
//   WB   : done=1, result valid; write R[rd] and status flags at the edge
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready                   instruction handshake
//   in_op,in_rd,in_rs1,in_rs2,
//   in_use_imm,in_imm                   decoded instruction fields
//   alu_a, alu_b, alu_code              to the ALU (registered)
//   alu_out, alu_carry, alu_zero        from the ALU
//   done, result                        writeback pulse and value
//   flag_c, flag_z                      status flags
//   dbg_addr, dbg_data                  combinational register-file peek
// -----------------------------------------------------------------------------
module alu_exec_ctrl
    import exec_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int RAW   = RAW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     in_op,
    input  logic [RAW-1:0] in_rd,
    input  logic [RAW-1:0] in_rs1,
    input  logic [RAW-1:0] in_rs2,
    input  logic           in_use_imm,
    input  logic [DW-1:0]  in_imm,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [2:0]     alu_code,
    input  logic [DW-1:0]  alu_out,
    input  logic           alu_carry,
    input  logic           alu_zero,
    output logic           done,
    output logic [DW-1:0]  result,
    output logic           flag_c,
    output logic           flag_z,
    input  logic [RAW-1:0] dbg_addr,
    output logic [DW-1:0]  dbg_data
);

    state_e         state_r;
    logic           in_ready_r;
    logic           done_r;
    logic [2:0]     op_r;
    logic [RAW-1:0] rd_r;
    logic [DW-1:0]  a_r;
    logic [DW-1:0]  b_r;
    logic [DW-1:0]  result_r;
    logic           carry_cap_r;
    logic           zero_cap_r;
    logic           flag_c_r;
    logic           flag_z_r;

    logic [DW-1:0]  rs1_data_s;
    logic [DW-1:0]  rs2_data_s;
    logic           wr_en_s;

    // The write happens on the edge that leaves WB, so the next accept in
    // IDLE always reads the updated register file: no bypass is needed.
    assign wr_en_s = (state_r == S_WB);

    reg_file #(
        .DW    (DW),
        .NREGS (NREGS),
        .RAW   (RAW)
    ) u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (in_rs1),
        .rd_data_a (rs1_data_s),
        .rd_addr_b (in_rs2),
        .rd_data_b (rs2_data_s),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wr_en_s),
        .wr_addr   (rd_r),
        .wr_data   (result_r)
    );

    // Controller FSM with operand latches, ALU capture and status flags.
    // in_ready/done are registered alongside the state so they always agree
    // with it. Operand latches are only loaded on accept, so the ALU inputs
    // hold their last values through WB and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            done_r      <= 1'b0;
            op_r        <= 3'b000;
            rd_r        <= {RAW{1'b0}};
            a_r         <= {DW{1'b0}};
            b_r         <= {DW{1'b0}};
            result_r    <= {DW{1'b0}};
            carry_cap_r <= 1'b0;
            zero_cap_r  <= 1'b0;
            flag_c_r    <= 1'b0;
            flag_z_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r       <= in_op;
                        rd_r       <= in_rd;
                        a_r        <= rs1_data_s;
                        b_r        <= in_use_imm ? in_imm : rs2_data_s;
                        in_ready_r <= 1'b0;
                        state_r    <= S_EXEC;
                    end else begin
                        in_ready_r <= 1'b1;
                        state_r    <= S_IDLE;
                    end
                    done_r <= 1'b0;
                end
                S_EXEC: begin
                    // ALU result is sampled only here, at the end of EXEC.
                    result_r    <= alu_out;
                    carry_cap_r <= alu_carry;
                    zero_cap_r  <= alu_zero;
                    done_r      <= 1'b1;
                    in_ready_r  <= 1'b0;
                    state_r     <= S_WB;
                end
                S_WB: begin
                    // Flags update even when rd=r0 discards the data write.
                    flag_z_r <= zero_cap_r;
                    if (op_updates_carry(op_r)) begin
                        flag_c_r <= carry_cap_r;
                    end else begin
                        flag_c_r <= flag_c_r;
                    end
                    done_r     <= 1'b0;
                    in_ready_r <= 1'b1;
                    state_r    <= S_IDLE;
                end
                default: begin
                    done_r     <= 1'b0;
                    in_ready_r <= 1'b1;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign done     = done_r;
    assign result   = result_r;
    assign flag_c   = flag_c_r;
    assign flag_z   = flag_z_r;
    assign alu_a    = a_r;
    assign alu_b    = b_r;
    assign alu_code = op_r;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_ctrl
// Directed bench for alu_exec_ctrl with a behavioural 16-bit ALU attached.
// ALU reference: ADD/SUB give a 17-bit {carry,out} (SUB carry = borrow),
// SHR/SHL shift operand A by one, NOT inverts A, zero = (out == 0).
// -----------------------------------------------------------------------------
module tb_alu_exec_ctrl;
    import exec_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic        in_use_imm;
    logic [15:0] in_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_code;
    logic [15:0] alu_out;
    logic        alu_carry;
    logic        alu_zero;
    logic        done;
    logic [15:0] result;
    logic        flag_c;
    logic        flag_z;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int errors = 0;
    int checks = 0;

    alu_exec_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_code   (alu_code),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .done       (done),
        .result     (result),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU sitting between the controller's outputs and inputs.
    logic [16:0] alu_wide;
    always_comb begin
        alu_wide = 17'h0;
        case (alu_code)
            OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            OP_SHR:  alu_wide = {alu_a[0], 1'b0, alu_a[15:1]};
            OP_SHL:  alu_wide = {alu_a[15], alu_a[14:0], 1'b0};
            OP_AND:  alu_wide = {1'b0, alu_a & alu_b};
            OP_OR:   alu_wide = {1'b0, alu_a | alu_b};
            OP_NOT:  alu_wide = {1'b0, ~alu_a};
            OP_XOR:  alu_wide = {1'b0, alu_a ^ alu_b};
            default: alu_wide = 17'h0;
        endcase
    end
    assign alu_out   = alu_wide[15:0];
    assign alu_carry = alu_wide[16];
    assign alu_zero  = (alu_wide[15:0] == 16'h0000);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction from IDLE and follow it through EXEC and WB.
    // Called just after a rising edge with the DUT idle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2, input logic use_imm,
                          input logic [15:0] imm, input logic [15:0] exp_res,
                          input logic [15:0] exp_reg, input logic exp_c, input logic exp_z);
        int n;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_use_imm = use_imm; in_imm = imm; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq({tag, "_ready_timeout"}, 32'd0, 32'd1);
        @(posedge clk);                     // accept edge T
        #1;
        in_valid = 1'b0;
        dbg_addr = rd;
        @(negedge clk);                     // EXEC
        check_eq({tag, "_exec_done"}, done, 1'b0);
        check_eq({tag, "_exec_ready"}, in_ready, 1'b0);
        check_eq({tag, "_exec_code"}, alu_code, op);
        @(negedge clk);                     // WB
        check_eq({tag, "_wb_done"}, done, 1'b1);
        check_eq({tag, "_wb_result"}, result, exp_res);
        @(posedge clk);                     // edge T+2
        #1;
        check_eq({tag, "_reg"}, dbg_data, exp_reg);
        check_eq({tag, "_flag_c"}, flag_c, exp_c);
        check_eq({tag, "_flag_z"}, flag_z, exp_z);
        check_eq({tag, "_idle_done"}, done, 1'b0);
        check_eq({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low_cnt;
        int done_cnt;

        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_rd = 3'd0;
        in_rs1 = 3'd0; in_rs2 = 3'd0; in_use_imm = 1'b0; in_imm = 16'h0000;
        dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle state after reset.
        check_eq("rst_ready", in_ready, 1'b1);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_flag_c", flag_c, 1'b0);
        check_eq("rst_flag_z", flag_z, 1'b0);
        check_eq("rst_alu_a", alu_a, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check_eq($sformatf("rst_dbg_r%0d", i), dbg_data, 16'h0000);
        end
        @(posedge clk);
        #1;

        // Immediate loads and a wrapping add.
        run_op("add_r1", OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h00FF, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
        run_op("add_r2", OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFF01, 16'hFF01, 16'hFF01, 1'b0, 1'b0);
        run_op("add_r3", OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);

        // Carry is retained by non-ADD opcodes.
        run_op("xor_r4", OP_XOR, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
        run_op("sub_r5", OP_SUB, 3'd5, 3'd1, 3'd0, 1'b1, 16'h0001, 16'h00FE, 16'h00FE, 1'b1, 1'b0);

        // r0 write with in_valid held high: two back-to-back instructions.
        in_op = OP_ADD; in_rd = 3'd0; in_rs1 = 3'd0; in_rs2 = 3'd0;
        in_use_imm = 1'b1; in_imm = 16'h0005; in_valid = 1'b1;
        dbg_addr = 3'd0;
        low_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_ready === 1'b0) low_cnt++;
            if (done === 1'b1) done_cnt++;
        end
        in_valid = 1'b0;
        check_eq("hold_ready_low", low_cnt, 32'd4);
        check_eq("hold_done_cnt", done_cnt, 32'd2);
        @(negedge clk);
        check_eq("r0_dbg", dbg_data, 16'h0000);
        check_eq("r0_flag_z", flag_z, 1'b0);
        check_eq("r0_flag_c", flag_c, 1'b0);
        check_eq("r0_ready", in_ready, 1'b1);
        @(negedge clk);
        check_eq("no_third_accept", in_ready, 1'b1);
        check_eq("no_third_done", done, 1'b0);
        @(posedge clk);
        #1;

        // Shifts, NOT and logic ops on r1 = 0x8001.
        run_op("ld_r1", OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h8001, 16'h8001, 16'h8001, 1'b0, 1'b0);
        run_op("shl_r2", OP_SHL, 3'd2, 3'd1, 3'd0, 1'b0, 16'h0000, 16'h0002, 16'h0002, 1'b0, 1'b0);
        run_op("shr_r3", OP_SHR, 3'd3, 3'd1, 3'd0, 1'b0, 16'h0000, 16'h4000, 16'h4000, 1'b0, 1'b0);
        run_op("not_r4", OP_NOT, 3'd4, 3'd1, 3'd0, 1'b0, 16'h0000, 16'h7FFE, 16'h7FFE, 1'b0, 1'b0);
        run_op("and_r5", OP_AND, 3'd5, 3'd1, 3'd0, 1'b1, 16'h00FF, 16'h0001, 16'h0001, 1'b0, 1'b0);
        run_op("or_r7", OP_OR, 3'd7, 3'd1, 3'd0, 1'b1, 16'h0F00, 16'h8F01, 16'h8F01, 1'b0, 1'b0);
        run_op("or_reg", OP_OR, 3'd6, 3'd2, 3'd3, 1'b0, 16'hFFFF, 16'h4002, 16'h4002, 1'b0, 1'b0);

        // Reset during EXEC aborts the instruction.
        in_op = OP_ADD; in_rd = 3'd6; in_rs1 = 3'd0; in_rs2 = 3'd0;
        in_use_imm = 1'b1; in_imm = 16'h1234; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("abort_in_exec", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_rst_done", done, 1'b0);
        check_eq("abort_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check_eq("abort_no_done", done_cnt, 32'd0);
        check_eq("abort_ready", in_ready, 1'b1);
        dbg_addr = 3'd6;
        #1;
        check_eq("abort_r6", dbg_data, 16'h0000);
        dbg_addr = 3'd1;
        #1;
        check_eq("abort_r1_cleared", dbg_data, 16'h0000);
        check_eq("abort_alu_b", alu_b, 16'h0000);
        @(posedge clk);
        #1;
        run_op("post_rst", OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
